// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master arbiter: FSM encoding, the bit
// layout of the SPI master control/status bytes, and a control-byte packer.
package spi_pkg;

    // Number of requesters sharing the SPI master.
    localparam int NUM_REQ = 2;

    // Width of the payload moved through the SPI master FIFOs.
    localparam int DATA_W = 128;

    // Control byte layout: launch strobe in bit 7, byte count minus 1 in 3:0.
    localparam int CTRL_W          = 8;
    localparam int CTRL_LAUNCH_BIT = 7;
    localparam int CTRL_LEN_LSB    = 0;
    localparam int CTRL_LEN_W      = 4;

    // Status byte layout: busy flag in bit 7.
    localparam int STATUS_W        = 8;
    localparam int STATUS_BUSY_BIT = 7;

    // Transaction sequencing states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LAUNCH    = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_RESP      = 3'd4
    } state_t;

    // Build the control byte that starts a transfer of len+1 bytes.
    function automatic logic [CTRL_W-1:0] pack_ctrl(input logic [CTRL_LEN_W-1:0] len);
        logic [CTRL_W-1:0] ctrl;
        ctrl = '0;
        ctrl[CTRL_LAUNCH_BIT] = 1'b1;
        ctrl[CTRL_LEN_LSB +: CTRL_LEN_W] = len;
        return ctrl;
    endfunction

endpackage

// File: rtl/spi_rr_arb2.sv
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and the last-grant register; the register only advances when the
// caller accepts the grant. After reset requester 0 has priority.
module spi_rr_arb2
    import spi_pkg::*;
(
    input  logic               clk,
    input  logic               rstn,
    input  logic [NUM_REQ-1:0] req,
    input  logic               update,
    output logic [NUM_REQ-1:0] grant
);

    // Index of the requester granted most recently.
    logic last;

    // Pick a single winner; on contention favour the one not served last.
    always_comb begin
        // NOTE: the default assignment on entry covers every path, so no latch is inferred.
        grant = '0;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = '0;
        endcase
    end

    // Remember who won, only when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            last <= 1'b1;
        end else if (update && (grant != '0)) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/spi_mst_arb.sv
// Front end that shares one SPI master between two requesters. It grants one
// transaction at a time, launches it on the master, waits for the busy flag
// to rise and fall (aborting if it never rises), and returns the read data to
// the owning requester with a one-cycle response pulse.
module spi_mst_arb
    import spi_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16,
    parameter int LEN_W       = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  req_ready,
    input  logic [DATA_W-1:0]   req_wdata0,
    input  logic [DATA_W-1:0]   req_wdata1,
    input  logic [LEN_W-1:0]    req_len0,
    input  logic [LEN_W-1:0]    req_len1,
    output logic [NUM_REQ-1:0]  rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic [DATA_W-1:0]   mst_wfifo,
    output logic [CTRL_W-1:0]   mst_ctrl,
    input  logic [DATA_W-1:0]   mst_rfifo,
    input  logic [STATUS_W-1:0] mst_status
);

    // Counter wide enough to hold TIMEOUT_CYC, so saturation never wraps.
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYC);

    state_t                state;
    logic                  id_q;
    logic [CNT_W-1:0]      cnt;
    logic [NUM_REQ-1:0]    grant;
    logic                  accept;
    logic                  busy;
    logic [DATA_W-1:0]     sel_wdata;
    logic [LEN_W-1:0]      sel_len;
    logic [STATUS_W-2:0]   unused_status;

    assign busy          = mst_status[STATUS_BUSY_BIT];
    assign unused_status = {mst_status[STATUS_W-1:STATUS_BUSY_BIT+1], mst_status[STATUS_BUSY_BIT-1:0]};

    // A request is only ever considered while idle; nothing is latched.
    assign accept = (state == ST_IDLE) && (req_valid != '0);

    spi_rr_arb2 u_arb (
        .clk    (clk),
        .rstn   (rstn),
        .req    (req_valid),
        .update (accept),
        .grant  (grant)
    );

    // Ready goes only to the winner, and only while idle and out of reset.
    assign req_ready = (rstn && (state == ST_IDLE)) ? grant : '0;

    // Payload of whichever requester won this cycle.
    assign sel_wdata = grant[1] ? req_wdata1 : req_wdata0;
    assign sel_len   = grant[1] ? req_len1   : req_len0;

    // Transaction sequencer; every master-facing and response output is registered here.
    always_ff @(posedge clk) begin
        // NOTE: wide data registers are reset too, because their zero value is visible on the ports.
        if (!rstn) begin
            state     <= ST_IDLE;
            id_q      <= 1'b0;
            cnt       <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            mst_wfifo <= '0;
            mst_ctrl  <= '0;
        end else begin
            // NOTE: non-blocking assignments let later statements override these pulse defaults cleanly.
            rsp_valid <= '0;
            mst_ctrl  <= '0;
            unique case (state)
                ST_IDLE: begin
                    if (accept) begin
                        id_q      <= grant[1];
                        mst_wfifo <= sel_wdata;
                        mst_ctrl  <= pack_ctrl(CTRL_LEN_W'(sel_len));
                        state     <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= '0;
                    state <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (busy) begin
                        state <= ST_WAIT_DONE;
                    end else if (cnt == CNT_LAST) begin
                        // Master never started: report an error with no data.
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                        mst_wfifo <= '0;
                        rsp_valid <= id_q ? 2'b10 : 2'b01;
                        state     <= ST_RESP;
                    end else if (cnt != CNT_SAT) begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_DONE: begin
                    // No timeout here: a started transfer is always waited out.
                    if (!busy) begin
                        rsp_err   <= 1'b0;
                        rsp_rdata <= mst_rfifo;
                        mst_wfifo <= '0;
                        rsp_valid <= id_q ? 2'b10 : 2'b01;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_mst_arb.sv
// Directed bench for spi_mst_arb with a behavioural SPI master model and a
// response scoreboard filled at grant time and drained on rsp_valid.
module tb_spi_mst_arb;

    logic         clk = 1'b0;
    logic         rstn;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_wdata0, req_wdata1;
    logic [3:0]   req_len0, req_len1;
    logic [1:0]   rsp_valid;
    logic [127:0] rsp_rdata;
    logic         rsp_err;
    logic [127:0] mst_wfifo;
    logic [7:0]   mst_ctrl;
    logic [127:0] mst_rfifo;
    logic [7:0]   mst_status;

    typedef struct {
        logic [1:0]   valid;
        logic [127:0] rdata;
        logic         err;
    } exp_t;

    exp_t sb[$];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int ready_cyc, rsp_cyc;
    int busy_seen = 0;

    // SPI master model knobs.
    bit           model_en = 1'b1;
    int           busy_lat = 1;
    int           busy_cyc = 2;
    logic [127:0] miso_xor = '0;
    logic [127:0] cap;

    spi_mst_arb #(.TIMEOUT_CYC(16), .LEN_W(4)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_wdata0 (req_wdata0),
        .req_wdata1 (req_wdata1),
        .req_len0   (req_len0),
        .req_len1   (req_len1),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mst_wfifo  (mst_wfifo),
        .mst_ctrl   (mst_ctrl),
        .mst_rfifo  (mst_rfifo),
        .mst_status (mst_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // SPI master: on launch, raise busy after busy_lat cycles, hold it for
    // busy_cyc cycles, then return the captured payload XOR miso_xor.
    initial begin
        mst_status = '0;
        mst_rfifo  = '0;
        forever begin
            @(negedge clk);
            if (rstn && model_en && mst_ctrl[7]) begin
                cap = mst_wfifo;
                for (int i = 0; i < busy_lat && rstn; i++) @(negedge clk);
                if (rstn) begin
                    mst_status[7] = 1'b1;
                    busy_seen++;
                end
                for (int i = 0; i < busy_cyc && rstn; i++) @(negedge clk);
                mst_rfifo     = cap ^ miso_xor;
                mst_status[7] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Raise the request mask, wait for a grant, check it, log the expected
    // response, and return at the negedge of the LAUNCH cycle.
    task automatic issue(input logic [1:0] mask, input logic [1:0] exp_grant,
                         input logic err_exp, input logic drop);
        int   n = 0;
        exp_t e;
        req_valid = mask;
        #1;
        while (req_ready == 2'b00 && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("grant", 128'(req_ready), 128'(exp_grant));
        ready_cyc = cyc;
        e.valid = exp_grant;
        e.err   = err_exp;
        e.rdata = err_exp ? 128'h0 : ((exp_grant[1] ? req_wdata1 : req_wdata0) ^ miso_xor);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (drop) req_valid = 2'b00;
    endtask

    // Wait (bounded) for a response, compare against the scoreboard head,
    // then confirm the pulse is one cycle and the data holds.
    task automatic wait_rsp(input int budget);
        int   n = 0;
        exp_t e;
        while (rsp_valid == 2'b00 && n < budget) begin
            @(negedge clk);
            n++;
        end
        rsp_cyc = cyc;
        check("rsp_seen", 128'(rsp_valid != 2'b00), 128'(1));
        if (sb.size() == 0) begin
            total++;
            bad++;
            $error("FAIL sb_underflow observed=%0d expected=1", sb.size());
        end else begin
            e = sb.pop_front();
            check("rsp_valid", 128'(rsp_valid), 128'(e.valid));
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", 128'(rsp_err), 128'(e.err));
            @(negedge clk);
            check("rsp_pulse", 128'(rsp_valid), 128'(0));
            check("rsp_hold", rsp_rdata, e.rdata);
        end
    endtask

    initial begin
        bit           stable;
        bit           stray;
        int           n;

        rstn       = 1'b0;
        req_valid  = 2'b00;
        req_wdata0 = '0;
        req_wdata1 = '0;
        req_len0   = '0;
        req_len1   = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst_ready", 128'(req_ready), 128'(0));
        check("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        check("rst_rdata", rsp_rdata, 128'(0));
        check("rst_err", 128'(rsp_err), 128'(0));
        check("rst_wfifo", mst_wfifo, 128'(0));
        check("rst_ctrl", 128'(mst_ctrl), 128'(0));
        rstn = 1'b1;

        // Single requester, one byte, loopback slave.
        req_wdata0 = 128'h5A << 120;
        req_len0   = 4'h0;
        miso_xor   = '0;
        busy_lat   = 1;
        busy_cyc   = 2;
        issue(2'b01, 2'b01, 1'b0, 1'b1);
        check("t1_ctrl", 128'(mst_ctrl), 128'(8'h80));
        check("t1_wfifo", mst_wfifo, 128'h5A << 120);
        @(negedge clk);
        check("t1_ctrl_once", 128'(mst_ctrl), 128'(0));
        wait_rsp(40);
        check("t1_busy_seen", 128'(busy_seen), 128'(1));

        // Timeout: master never raises busy.
        model_en   = 1'b0;
        req_wdata1 = 128'hDEAD_BEEF;
        req_len1   = 4'h3;
        issue(2'b10, 2'b10, 1'b1, 1'b1);
        wait_rsp(60);
        check("to_latency", 128'(rsp_cyc - ready_cyc), 128'(18));
        check("to_wfifo", mst_wfifo, 128'(0));
        model_en = 1'b1;

        // Contention across three transactions: 0, 1, 0.
        miso_xor   = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        req_wdata0 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        req_wdata1 = 128'h9999_AAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0000;
        busy_cyc   = 3;
        issue(2'b11, 2'b01, 1'b0, 1'b0);
        wait_rsp(40);
        issue(2'b11, 2'b10, 1'b0, 1'b0);
        wait_rsp(40);
        issue(2'b11, 2'b01, 1'b0, 1'b1);
        wait_rsp(40);

        // Multi-byte on requester 1, payload held while busy.
        req_wdata1 = 128'hCAFE_F00D_0BAD_BEEF_1234_5678_9ABC_DEF0;
        req_len1   = 4'hF;
        busy_lat   = 2;
        busy_cyc   = 6;
        issue(2'b10, 2'b10, 1'b0, 1'b1);
        check("mb_ctrl", 128'(mst_ctrl), 128'(8'h8F));
        stable = 1'b1;
        n = 0;
        while (rsp_valid == 2'b00 && n < 40) begin
            if (mst_wfifo !== req_wdata1) stable = 1'b0;
            @(negedge clk);
            n++;
        end
        check("mb_wfifo_stable", 128'(stable), 128'(1));
        wait_rsp(40);
        check("mb_wfifo_clear", mst_wfifo, 128'(0));

        // Reset while the master is busy (WAIT_DONE).
        busy_lat = 1;
        busy_cyc = 20;
        req_wdata0 = 128'h7777_0000_7777_0000_7777_0000_7777_0000;
        issue(2'b01, 2'b01, 1'b0, 1'b1);
        n = 0;
        while (mst_status[7] == 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rr_busy_rise", 128'(mst_status[7]), 128'(1));
        repeat (2) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        check("rr_rdata", rsp_rdata, 128'(0));
        check("rr_wfifo", mst_wfifo, 128'(0));
        check("rr_small", 128'({req_ready, rsp_valid, rsp_err, mst_ctrl}), 128'(0));
        rstn = 1'b1;
        sb.delete();
        stray = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) stray = 1'b1;
        end
        check("rr_no_rsp", 128'(stray), 128'(0));
        busy_cyc = 3;
        issue(2'b01, 2'b01, 1'b0, 1'b1);
        wait_rsp(40);

        // Back-to-back: re-request in the IDLE cycle right after RESP.
        req_wdata0 = 128'h0F0F_0F0F_F0F0_F0F0_0F0F_0F0F_F0F0_F0F0;
        issue(2'b01, 2'b01, 1'b0, 1'b1);
        check("b2b_no_gap", 128'(ready_cyc - rsp_cyc), 128'(1));
        check("b2b_ctrl", 128'(mst_ctrl), 128'(8'h80));
        wait_rsp(40);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_mst_arb.md
SPI_MST_ARB -- requirements
Module: spi_mst_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 16: maximum cycles in WAIT_BUSY before the transaction is aborted.
REQ-002 SHALL have parameter LEN_W, default 4: width of the requester payload-length field.
REQ-003 SHALL have port clk, input, 1: the single clock; reset is synchronous and active-low.
REQ-004 SHALL have port rstn, input, 1: synchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 2: per-requester transaction request, bit i for requester i.
REQ-006 SHALL have port req_ready, output, 2: per-requester accept; a transaction transfers when valid&ready.
REQ-007 SHALL have port req_wdata0/req_wdata1, input, 128 each: write payload, MSB first.
REQ-008 SHALL have port req_len0/req_len1, input, LEN_W each: payload length in bytes minus 1.
REQ-009 SHALL have port rsp_valid, output, 2: one-cycle completion pulse to the owning requester.
REQ-010 SHALL have port rsp_rdata, output, 128: read data, valid with rsp_valid.
REQ-011 SHALL have port rsp_err, output, 1: timeout flag, valid with rsp_valid.
REQ-012 SHALL have ports mst_wfifo (output, 128), mst_ctrl (output, 8), mst_rfifo (input, 128) and mst_status (input, 8), all connected to the SPI master.

Function
REQ-013 SHALL implement FSM states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and RESP.
REQ-014 IDLE: when any req_valid is set, SHALL assert req_ready for exactly the granted requester for one cycle, capture its wdata, len and id, and go to LAUNCH next cycle.
REQ-015 Arbitration SHALL be round-robin: with both requesters valid, grant the one not last granted; with one valid, grant it; last-grant SHALL reset to 1, so requester 0 wins first.
REQ-016 LAUNCH: SHALL drive mst_ctrl = {1'b1, 3'b0, len} for exactly one cycle, then go to WAIT_BUSY; mst_ctrl[7] SHALL be 0 in every other state.
REQ-017 mst_wfifo SHALL hold the captured wdata from LAUNCH through WAIT_DONE, and SHALL be 0 otherwise.
REQ-018 WAIT_BUSY: when mst_status[7]=1, SHALL go to WAIT_DONE.
REQ-019 WAIT_BUSY: when mst_status[7]=0 after TIMEOUT_CYC cycles, SHALL set the error flag and go to RESP.
REQ-020 WAIT_DONE: when mst_status[7]=0, SHALL capture mst_rfifo into rsp_rdata and go to RESP; WAIT_DONE SHALL have no timeout.
REQ-021 RESP: SHALL pulse rsp_valid[id] for one cycle with rsp_err, then return to IDLE; rsp_rdata and rsp_err SHALL hold until the next RESP.
REQ-022 On a timeout, rsp_rdata SHALL be 0.
REQ-023 No new grant SHALL occur before RESP completes, giving at most one outstanding transaction.
REQ-024 Back-to-back operation: a requester may be granted in the IDLE cycle immediately following RESP.
REQ-025 A req_valid deasserted before grant SHALL be treated as no request; requests SHALL NOT be latched.
REQ-026 The timeout counter SHALL saturate, not wrap, and SHALL clear on entry to WAIT_BUSY.

Reset
REQ-027 With rstn=0 at a clock edge, SHALL put the FSM in IDLE and set last-grant=1, and set req_ready, rsp_valid, rsp_rdata, rsp_err, mst_wfifo, mst_ctrl and the timeout counter to 0.
REQ-028 A reset mid-transaction SHALL abandon it with no rsp_valid issued.

Structure
REQ-029 FSM state encodings and the mst_ctrl/mst_status bit positions (launch bit 7, length bits 3:0, busy bit 7) SHALL live in shared package spi_pkg.
REQ-030 The round-robin grant logic SHALL be a sub-module spi_rr_arb2 (2 requests, last-grant register, grant one-hot output).

Verification
REQ-031 Single requester: req_valid=01, wdata0=128'h5A<<120, len0=0 -> one-cycle mst_ctrl=8'h80, busy observed, then rsp_valid=01 with rsp_rdata=looped miso byte and rsp_err=0.
REQ-032 Contention: req_valid=11 held across three transactions -> grants in order 0,1,0, and each rsp_valid goes to the matching bit.
REQ-033 Timeout: mst_status tied to 0, TIMEOUT_CYC=16 -> rsp_valid with rsp_err=1 and rsp_rdata=0 about 18 cycles after accept.
REQ-034 Multi-byte: len1=4'hF -> mst_ctrl=8'h8F, and mst_wfifo is held stable until busy falls.
REQ-035 Reset asserted during WAIT_DONE -> all outputs 0 the next cycle, no rsp_valid, and the next request is served normally.
REQ-036 Back-to-back: req0 re-asserted in the cycle after its RESP -> granted in that IDLE cycle with no idle gap.
